// File: rtl/aes_128_inv_control_4cyc.sv
// Control sequencer for the AES-128 inverse cipher: runs a forward key-expansion pass into an
// 11-entry round-key RAM, then sequences 4-cycle decryption rounds reading keys 10 down to 0.
module aes_128_inv_control_4cyc #(
    parameter int RK_AW = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             kill_n,
    input  logic             key_en,
    input  logic             in_en,
    output logic             start,
    output logic             key_exp_en,
    output logic             rk_wr_en,
    output logic             rk_rd_en,
    output logic [RK_AW-1:0] rk_addr,
    output logic             en_inv_mixcol,
    output logic             key_valid,
    output logic             idle,
    output logic             out_en,
    output logic             in_en_collision_irq_pulse,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_EXP = 2'd1,
        READY   = 2'd2,
        DEC     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(43);
    localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(40);
    localparam logic [CNT_W-1:0] MIX_LAST = CNT_W'(35);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(38);
    localparam logic [RK_AW-1:0] ADDR_FIRST_DEC = RK_AW'(10);
    localparam logic [RK_AW-1:0] ADDR_TOP_RD    = RK_AW'(9);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             key_accept;
    logic             dec_accept;
    logic             reject;
    logic             exp_done;
    logic             dec_done;
    logic             wr_nx;
    logic             rd_nx;
    logic             mix_nx;
    logic             rd_q;
    logic [RK_AW-1:0] addr_q;
    logic [RK_AW-1:0] addr_nx;

    // A key load always wins over a simultaneous ciphertext strobe.
    always_comb begin
        key_accept = key_en & ((state == IDLE) | (state == READY));
        dec_accept = in_en & ~key_en & (state == READY);
        reject     = (key_en & ~key_accept) | (in_en & ~dec_accept);
        exp_done   = (state == KEY_EXP) && (cnt == EXP_LAST);
        dec_done   = (state == DEC) && (cnt == DEC_LAST);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (key_accept) begin
                    state_nx = KEY_EXP;
                    cnt_nx   = '0;
                end
            end
            KEY_EXP: begin
                if (exp_done) begin
                    state_nx = READY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            READY: begin
                if (key_accept) begin
                    state_nx = KEY_EXP;
                    cnt_nx   = '0;
                end else if (dec_accept) begin
                    state_nx = DEC;
                    cnt_nx   = '0;
                end
            end
            DEC: begin
                if (dec_done) begin
                    state_nx = READY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Strobes are registered, so they are derived from the next state/count.
    always_comb begin
        wr_nx  = (state_nx == KEY_EXP) && (cnt_nx[1:0] == 2'd3);
        rd_nx  = (state_nx == DEC) && (cnt_nx[1:0] == 2'd2) && (cnt_nx <= RD_LAST);
        mix_nx = (state_nx == DEC) && (cnt_nx <= MIX_LAST);
        if (wr_nx) begin
            addr_nx = RK_AW'(cnt_nx[CNT_W-1:2]);
        end else if (rd_nx) begin
            addr_nx = ADDR_TOP_RD - RK_AW'(cnt_nx[CNT_W-1:2]);
        end else if (dec_accept) begin
            addr_nx = ADDR_FIRST_DEC;
        end else begin
            addr_nx = addr_q;
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state                     <= IDLE;
            cnt                       <= '0;
            key_exp_en                <= 1'b0;
            rk_wr_en                  <= 1'b0;
            rd_q                      <= 1'b0;
            addr_q                    <= '0;
            en_inv_mixcol             <= 1'b0;
            key_valid                 <= 1'b0;
            idle                      <= 1'b0;
            out_en                    <= 1'b0;
            in_en_collision_irq_pulse <= 1'b0;
        end else begin
            state                     <= state_nx;
            cnt                       <= cnt_nx;
            key_exp_en                <= (state_nx == KEY_EXP);
            rk_wr_en                  <= wr_nx;
            rd_q                      <= rd_nx;
            addr_q                    <= addr_nx;
            en_inv_mixcol             <= mix_nx;
            // Busy indication keeps the inherited "idle" name although it is high when active.
            idle                      <= (state_nx == KEY_EXP) || (state_nx == DEC);
            out_en                    <= dec_done;
            in_en_collision_irq_pulse <= reject;
            if (key_accept) begin
                key_valid <= 1'b0;
            end else if (exp_done) begin
                key_valid <= 1'b1;
            end
        end
    end

    // The initial AddRoundKey read is issued in the same cycle the ciphertext is taken.
    assign start     = dec_accept;
    assign rk_rd_en  = rd_q | dec_accept;
    assign rk_addr   = dec_accept ? ADDR_FIRST_DEC : addr_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_aes_128_inv_control_4cyc.sv
// Self-checking bench for aes_128_inv_control_4cyc: expected RAM strobes are queued as
// {cycle offset, address} when stimulus starts and popped as the DUT issues them.
module tb_aes_128_inv_control_4cyc;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_KEY_EXP = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;

    logic       clk;
    logic       kill_n;
    logic       key_en;
    logic       in_en;
    logic       start;
    logic       key_exp_en;
    logic       rk_wr_en;
    logic       rk_rd_en;
    logic [3:0] rk_addr;
    logic       en_inv_mixcol;
    logic       key_valid;
    logic       idle;
    logic       out_en;
    logic       irq;
    logic [1:0] dbg_state;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];

    aes_128_inv_control_4cyc #(.RK_AW(4), .CNT_W(6)) dut (
        .clk                       (clk),
        .kill_n                    (kill_n),
        .key_en                    (key_en),
        .in_en                     (in_en),
        .start                     (start),
        .key_exp_en                (key_exp_en),
        .rk_wr_en                  (rk_wr_en),
        .rk_rd_en                  (rk_rd_en),
        .rk_addr                   (rk_addr),
        .en_inv_mixcol             (en_inv_mixcol),
        .key_valid                 (key_valid),
        .idle                      (idle),
        .out_en                    (out_en),
        .in_en_collision_irq_pulse (irq),
        .dbg_state                 (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        kill_n = 1'b0;
        key_en = 1'b0;
        in_en  = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({start, key_exp_en, rk_wr_en, rk_rd_en, en_inv_mixcol, idle, out_en, irq} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b exp=00000000",
                     {start, key_exp_en, rk_wr_en, rk_rd_en, en_inv_mixcol, idle, out_en, irq});
        end
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_valid got=%b exp=0", key_valid);
        end
        n_checks++;
        if (rk_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_rk_addr got=%0d exp=0", rk_addr);
        end
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE);
        end
        @(negedge clk);
        kill_n = 1'b1;
    endtask

    task automatic test_idle_reject();
        @(negedge clk);
        in_en = 1'b1;
        #1;
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_reject_start got=%b exp=0", start);
        end
        @(negedge clk);
        in_en = 1'b0;
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_reject_irq got=%b exp=1", irq);
        end
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL idle_reject_state got=%0d exp=%0d", dbg_state, S_IDLE);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_reject_irq_single got=%b exp=0", irq);
        end
    endtask

    // both=1: key_en and in_en together (expected from READY).
    task automatic test_key_exp(input bit both);
        logic [15:0] e;
        logic [11:0] o12;
        logic        exp_busy;
        logic        exp_irq;
        exp_q.delete();
        @(negedge clk);
        key_en = 1'b1;
        in_en  = both;
        #1;
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL key_exp_start got=%b exp=0", start);
        end
        for (int i = 0; i <= 10; i++) exp_q.push_back({12'(4 + 4 * i), 4'(i)});
        for (int off = 1; off <= 47; off++) begin
            @(negedge clk);
            key_en = (off == 30);
            in_en  = (off == 20);
            #1;
            o12      = 12'(off);
            exp_busy = (off <= 44);
            exp_irq  = (off == 1 && both) || off == 21 || off == 31;
            n_checks++;
            if (idle !== exp_busy || key_exp_en !== exp_busy) begin
                n_fail++;
                $display("FAIL key_exp_busy off=%0d got idle=%b key_exp_en=%b exp=%b", off, idle, key_exp_en, exp_busy);
            end
            n_checks++;
            if (key_valid !== !exp_busy) begin
                n_fail++;
                $display("FAIL key_exp_key_valid off=%0d got=%b exp=%b", off, key_valid, !exp_busy);
            end
            n_checks++;
            if (irq !== exp_irq) begin
                n_fail++;
                $display("FAIL key_exp_irq off=%0d got=%b exp=%b", off, irq, exp_irq);
            end
            n_checks++;
            if (start !== 1'b0 || rk_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL key_exp_no_read off=%0d got start=%b rd=%b exp=0", off, start, rk_rd_en);
            end
            if (rk_wr_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL key_exp_extra_write off=%0d addr=%0d exp=none", off, rk_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({o12, rk_addr} !== e) begin
                        n_fail++;
                        $display("FAIL key_exp_write got off=%0d addr=%0d exp off=%0d addr=%0d", off, rk_addr, e[15:4], e[3:0]);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL key_exp_missing_writes got_left=%0d exp=0", exp_q.size());
        end
        n_checks++;
        if (dbg_state !== S_READY) begin
            n_fail++;
            $display("FAIL key_exp_end_state got=%0d exp=%0d", dbg_state, S_READY);
        end
    endtask

    // chained=1: start in the same cycle the previous block's out_en is high.
    task automatic test_decrypt(input bit chained, input bit collide);
        logic [15:0] e;
        logic [11:0] o12;
        logic        exp_irq;
        exp_q.delete();
        if (!chained) @(negedge clk);
        key_en = 1'b0;
        in_en  = 1'b1;
        #1;
        n_checks++;
        if (start !== 1'b1 || rk_rd_en !== 1'b1 || rk_addr !== 4'd10) begin
            n_fail++;
            $display("FAIL dec_start got start=%b rd=%b addr=%0d exp start=1 rd=1 addr=10", start, rk_rd_en, rk_addr);
        end
        for (int k = 0; k <= 9; k++) exp_q.push_back({12'(3 + 4 * k), 4'(9 - k)});
        for (int off = 1; off <= 42; off++) begin
            @(negedge clk);
            in_en  = collide && (off == 10);
            key_en = collide && (off == 11);
            #1;
            o12     = 12'(off);
            exp_irq = collide && (off == 11 || off == 12);
            n_checks++;
            if (idle !== (off <= 41)) begin
                n_fail++;
                $display("FAIL dec_busy off=%0d got=%b exp=%b", off, idle, (off <= 41));
            end
            n_checks++;
            if (en_inv_mixcol !== (off <= 36)) begin
                n_fail++;
                $display("FAIL dec_mixcol off=%0d got=%b exp=%b", off, en_inv_mixcol, (off <= 36));
            end
            n_checks++;
            if (out_en !== (off == 42)) begin
                n_fail++;
                $display("FAIL dec_out_en off=%0d got=%b exp=%b", off, out_en, (off == 42));
            end
            n_checks++;
            if (irq !== exp_irq) begin
                n_fail++;
                $display("FAIL dec_irq off=%0d got=%b exp=%b", off, irq, exp_irq);
            end
            n_checks++;
            if (key_valid !== 1'b1 || start !== 1'b0 || rk_wr_en !== 1'b0 || key_exp_en !== 1'b0) begin
                n_fail++;
                $display("FAIL dec_static off=%0d got kv=%b start=%b wr=%b kexp=%b exp kv=1 others=0",
                         off, key_valid, start, rk_wr_en, key_exp_en);
            end
            if (rk_rd_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dec_extra_read off=%0d addr=%0d exp=none", off, rk_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({o12, rk_addr} !== e) begin
                        n_fail++;
                        $display("FAIL dec_read got off=%0d addr=%0d exp off=%0d addr=%0d", off, rk_addr, e[15:4], e[3:0]);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL dec_missing_reads got_left=%0d exp=0", exp_q.size());
        end
        n_checks++;
        if (dbg_state !== S_READY) begin
            n_fail++;
            $display("FAIL dec_end_state got=%0d exp=%0d", dbg_state, S_READY);
        end
    endtask

    task automatic test_back_to_back();
        test_decrypt(1'b0, 1'b0);
        test_decrypt(1'b1, 1'b0);
    endtask

    task automatic test_kill();
        @(negedge clk);
        in_en = 1'b1;
        #1;
        n_checks++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_pre_start got=%b exp=1", start);
        end
        for (int off = 1; off <= 19; off++) begin
            @(negedge clk);
            in_en = 1'b0;
        end
        @(negedge clk);
        kill_n = 1'b0;
        #1;
        n_checks++;
        if ({start, key_exp_en, rk_wr_en, rk_rd_en, en_inv_mixcol, idle, out_en, irq, key_valid} !== 9'h000) begin
            n_fail++;
            $display("FAIL kill_outputs got=%b exp=000000000",
                     {start, key_exp_en, rk_wr_en, rk_rd_en, en_inv_mixcol, idle, out_en, irq, key_valid});
        end
        n_checks++;
        if (rk_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL kill_rk_addr got=%0d exp=0", rk_addr);
        end
        @(negedge clk);
        kill_n = 1'b1;
        for (int off = 0; off < 25; off++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_en !== 1'b0 || rk_rd_en !== 1'b0 || rk_wr_en !== 1'b0 || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL kill_quiet off=%0d got out=%b rd=%b wr=%b kv=%b exp=0", off, out_en, rk_rd_en, rk_wr_en, key_valid);
            end
        end
        @(negedge clk);
        in_en = 1'b1;
        #1;
        n_checks++;
        if (start !== 1'b0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL kill_reject_start got start=%b state=%0d exp start=0 state=%0d", start, dbg_state, S_IDLE);
        end
        @(negedge clk);
        in_en = 1'b0;
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_reject_irq got=%b exp=1", irq);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_reject();
        test_key_exp(1'b0);
        test_decrypt(1'b0, 1'b1);
        test_back_to_back();
        test_key_exp(1'b1);
        n_checks++;
        if (dbg_state === S_KEY_EXP) begin
            n_fail++;
            $display("FAIL reload_state got=%0d exp=%0d", dbg_state, S_READY);
        end
        test_kill();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
